// File: rtl/zbt_sched_pkg.sv
// zbt_sched_pkg: shared types and default widths for the ZBT slot scheduler
package zbt_sched_pkg;

  localparam int DEF_ADDR_W  = 19;
  localparam int DEF_DATA_W  = 36;
  localparam int DEF_ZBT_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    PH_READ  = 1'b0,
    PH_WRITE = 1'b1
  } phase_e;

endpackage

// File: rtl/zbt_wr_fifo.sv
// zbt_wr_fifo: small synchronous FIFO buffering {addr, data} write words
module zbt_wr_fifo #(
  parameter int AW    = 19,
  parameter int DW    = 36,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW:0]   count_o
);

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, rp_q;
  logic [PW:0]      cnt_q;

  assign full_o            = cnt_q == (PW+1)'(DEPTH);
  assign empty_o           = cnt_q == '0;
  assign count_o           = cnt_q;
  assign {addr_o, data_o}  = mem_q[rp_q];

  // storage array needs no reset; only pointers define what is valid
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wp_q] <= {addr_i, data_i};

  // pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + PW'(1);
      if (pop_i) rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end

endmodule

// File: rtl/zbt_slot_sched.sv
// zbt_slot_sched: even/odd slot arbiter between display reads and buffered pixel writes on one ZBT bank
module zbt_slot_sched
  import zbt_sched_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int ZBT_LAT    = DEF_ZBT_LAT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic [ADDR_W-1:0] zbt_addr_o,
  output logic              zbt_we_n_o,
  output logic [DATA_W-1:0] zbt_wdata_o,
  input  logic [DATA_W-1:0] zbt_rdata_i,
  output logic              busy_o,
  output logic [1:0]        state_o
);

  localparam int CW = $clog2(FIFO_DEPTH);

  state_e state_q, state_d;
  phase_e phase_q, phase_d;

  logic [ADDR_W-1:0] zbt_addr_q, zbt_addr_d;
  logic              zbt_we_n_q, zbt_we_n_d;
  logic [DATA_W-1:0] zbt_wdata_q, zbt_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic [ZBT_LAT-1:0]             wvld_q, wvld_d;
  logic [ZBT_LAT-1:0][DATA_W-1:0] wdat_q, wdat_d;
  logic [ZBT_LAT:0]               rvld_q, rvld_d;

  logic              push, do_rd, do_wr, wr_inflight;
  logic              full, empty;
  logic [CW:0]       count;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;

  assign wr_ready_o  = !full && state_q != ST_DRAIN;
  assign push        = wr_valid_i && wr_ready_o;
  assign do_rd       = state_q == ST_RUN && phase_q == PH_READ && rd_req_i;
  assign do_wr       = !empty && (state_q == ST_DRAIN || (state_q == ST_RUN && phase_q == PH_WRITE));
  assign busy_o      = state_q != ST_IDLE || |wvld_q;
  assign state_o     = state_q;
  assign zbt_addr_o  = zbt_addr_q;
  assign zbt_we_n_o  = zbt_we_n_q;
  assign zbt_wdata_o = zbt_wdata_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;

  zbt_wr_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .addr_i  (wr_addr_i),
    .data_i  (wr_data_i),
    .pop_i   (do_wr),
    .addr_o  (f_addr),
    .data_o  (f_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // next state, slot phase and bank command; idle slots hold the address bus
  always_comb begin
    state_d     = state_q == ST_IDLE ? (start_i ? ST_RUN : ST_IDLE) :
                  state_q == ST_RUN  ? (stop_i ? ST_DRAIN : ST_RUN) :
                  state_q == ST_DRAIN ? ((count == '0 && !wr_inflight) ? ST_IDLE : ST_DRAIN) :
                  ST_IDLE;
    phase_d     = (state_q == ST_RUN && phase_q == PH_READ) ? PH_WRITE : PH_READ;
    zbt_addr_d  = do_rd ? rd_addr_i : do_wr ? f_addr : zbt_addr_q;
    zbt_we_n_d  = !do_wr;
    rd_valid_d  = rvld_q[ZBT_LAT] && state_d != ST_DRAIN;
    rd_data_d   = rd_valid_d ? zbt_rdata_i : rd_data_q;
    zbt_wdata_d = wvld_q[ZBT_LAT-1] ? wdat_q[ZBT_LAT-1] : zbt_wdata_q;
    rvld_d      = {rvld_q[ZBT_LAT-1:0], do_rd};
  end

  // latency shift registers; the exiting write stage no longer blocks the drain exit
  always_comb begin
    wr_inflight = 1'b0;
    wvld_d      = '0;
    wdat_d      = '0;
    wvld_d[0]   = do_wr;
    wdat_d[0]   = f_data;
    for (int i = 1; i < ZBT_LAT; i++) begin
      wvld_d[i] = wvld_q[i-1];
      wdat_d[i] = wdat_q[i-1];
    end
    for (int i = 0; i < ZBT_LAT - 1; i++) wr_inflight = wr_inflight | wvld_q[i];
  end

  // FSM, phase, registered bank pins and both pipelines; reset drops anything in flight
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_READ;
      zbt_addr_q  <= '0;
      zbt_we_n_q  <= 1'b1;
      zbt_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wvld_q      <= '0;
      wdat_q      <= '0;
      rvld_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      zbt_addr_q  <= zbt_addr_d;
      zbt_we_n_q  <= zbt_we_n_d;
      zbt_wdata_q <= zbt_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wvld_q      <= wvld_d;
      wdat_q      <= wdat_d;
      rvld_q      <= rvld_d;
    end

endmodule

// File: tb/tb_zbt_slot_sched.sv
// tb_zbt_slot_sched: directed checks of slot scheduling, latencies, drain and reset
module tb_zbt_slot_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, rd_req = 1'b0, wr_valid = 1'b0;
  logic [18:0] rd_addr = '0, wr_addr = '0;
  logic [35:0] wr_data = '0;
  logic [35:0] rd_data, zbt_wdata, zbt_rdata;
  logic        rd_valid, wr_ready, zbt_we_n, busy;
  logic [18:0] zbt_addr;
  logic [1:0]  state;

  int ncmp = 0;
  int nerr = 0;

  logic [18:0] a1, a2;
  logic        we_h0 = 1'b0, we_h1 = 1'b0, we_h2 = 1'b0;
  logic [18:0] ad_h0, ad_h1, ad_h2;
  logic [35:0] bank [int];
  logic [18:0] wlog [$];

  localparam logic [35:0] WA = 36'h1_2345_6789;
  localparam logic [35:0] WB = 36'hF_EDCB_A987;
  localparam logic [35:0] WD = 36'h5_0000_0000;

  always #5 clk = ~clk;

  zbt_slot_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .stop_i      (stop),
    .rd_req_i    (rd_req),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .wr_valid_i  (wr_valid),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_ready_o  (wr_ready),
    .zbt_addr_o  (zbt_addr),
    .zbt_we_n_o  (zbt_we_n),
    .zbt_wdata_o (zbt_wdata),
    .zbt_rdata_i (zbt_rdata),
    .busy_o      (busy),
    .state_o     (state)
  );

  function automatic logic [35:0] rdm(input logic [18:0] a);
    return {17'h0, a} ^ 36'hA_5A5A_5A5A;
  endfunction

  // bank read model: data for the address registered two edges ago
  always @(posedge clk) begin
    a1 <= zbt_addr;
    a2 <= a1;
  end
  assign zbt_rdata = rdm(a2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one edge, then sample; bank write model pairs each write address with data two edges later
  task automatic tick();
    @(posedge clk);
    #1;
    we_h2 = we_h1; ad_h2 = ad_h1;
    we_h1 = we_h0; ad_h1 = ad_h0;
    we_h0 = !zbt_we_n; ad_h0 = zbt_addr;
    if (we_h2) begin
      bank[int'(ad_h2)] = zbt_wdata;
      wlog.push_back(ad_h2);
    end
  endtask

  initial begin
    bit          exp_rdy [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
    logic [18:0] exp_log [10] = '{19'h1000, 19'h1001, 19'h2000, 19'h2001, 19'h2002,
                                  19'h2003, 19'h2004, 19'h2005, 19'h2006, 19'h2007};
    int k;
    tick();
    chk("rst_addr", zbt_addr, 0);
    chk("rst_we_n", zbt_we_n, 1);
    chk("rst_wdata", zbt_wdata, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rvalid", rd_valid, 0);
    chk("rst_wready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    rst_n = 1'b1;
    start = 1'b1; rd_req = 1'b1; rd_addr = 19'h10;
    tick(); // E1
    chk("e1_state", state, 1);
    chk("e1_we_n", zbt_we_n, 1);
    start = 1'b0;
    tick(); // E2 read 0x10
    chk("e2_addr", zbt_addr, 19'h10);
    chk("e2_we_n", zbt_we_n, 1);
    chk("e2_busy", busy, 1);
    rd_addr = 19'h11;
    tick(); // E3 empty write slot
    chk("e3_hold", zbt_addr, 19'h10);
    chk("e3_we_n", zbt_we_n, 1);
    chk("e3_rvalid", rd_valid, 0);
    tick(); // E4 read 0x11
    chk("e4_addr", zbt_addr, 19'h11);
    chk("e4_rvalid", rd_valid, 0);
    rd_req = 1'b0;
    tick(); // E5
    chk("e5_rvalid", rd_valid, 1);
    chk("e5_rdata", rd_data, rdm(19'h10));
    tick(); // E6
    chk("e6_rvalid", rd_valid, 0);
    tick(); // E7
    chk("e7_rvalid", rd_valid, 1);
    chk("e7_rdata", rd_data, rdm(19'h11));
    wr_valid = 1'b1; wr_addr = 19'h1000; wr_data = WA;
    tick(); // E8 push A
    chk("e8_we_n", zbt_we_n, 1);
    wr_addr = 19'h1001; wr_data = WB;
    tick(); // E9 pop A, push B
    chk("e9_addr", zbt_addr, 19'h1000);
    chk("e9_we_n", zbt_we_n, 0);
    wr_valid = 1'b0;
    tick(); // E10
    chk("e10_we_n", zbt_we_n, 1);
    chk("e10_wdata", zbt_wdata, 0);
    tick(); // E11 pop B
    chk("e11_addr", zbt_addr, 19'h1001);
    chk("e11_we_n", zbt_we_n, 0);
    chk("e11_wdata", zbt_wdata, WA);
    tick(); // E12
    chk("e12_wdata", zbt_wdata, WA);
    tick(); // E13
    chk("e13_wdata", zbt_wdata, WB);
    k = 0;
    wr_valid = 1'b1; wr_addr = 19'h2000; wr_data = WD;
    for (int c = 0; c < 10; c++) begin // E14..E23
      chk("burst_rdy", wr_ready, exp_rdy[c]);
      tick();
      if (exp_rdy[c]) k++;
      wr_addr = 19'h2000 + 19'(k);
      wr_data = WD | 36'(k);
    end
    wr_valid = 1'b0;
    stop = 1'b1;
    tick(); // E24 enter DRAIN with D5..D7 buffered
    chk("e24_state", state, 2);
    chk("e24_wready", wr_ready, 0);
    stop = 1'b0; rd_req = 1'b1; rd_addr = 19'h33;
    tick(); // E25
    chk("e25_addr", zbt_addr, 19'h2005);
    chk("e25_we_n", zbt_we_n, 0);
    tick(); // E26
    chk("e26_addr", zbt_addr, 19'h2006);
    chk("e26_we_n", zbt_we_n, 0);
    tick(); // E27 last pop
    chk("e27_addr", zbt_addr, 19'h2007);
    chk("e27_we_n", zbt_we_n, 0);
    tick(); // E28
    chk("e28_we_n", zbt_we_n, 1);
    chk("e28_addr", zbt_addr, 19'h2007);
    chk("e28_state", state, 2);
    chk("e28_busy", busy, 1);
    chk("e28_rvalid", rd_valid, 0);
    tick(); // E29 back to IDLE
    chk("e29_state", state, 0);
    chk("e29_busy", busy, 0);
    chk("e29_wready", wr_ready, 1);
    chk("e29_rvalid", rd_valid, 0);
    chk("log_size", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) chk("log_order", wlog[i], exp_log[i]);
    chk("bank_a", bank[32'h1000], WA);
    chk("bank_b", bank[32'h1001], WB);
    for (int i = 0; i < 8; i++) chk("bank_d", bank[32'h2000 + i], WD | 36'(i));
    start = 1'b1; rd_req = 1'b0; wr_valid = 1'b1; wr_addr = 19'h3000; wr_data = 36'h9_8765_4321;
    tick(); // E30
    chk("e30_state", state, 1);
    start = 1'b0; wr_addr = 19'h3001; wr_data = 36'h3_3333_3333; rd_req = 1'b1; rd_addr = 19'h40;
    tick(); // E31 read 0x40, push second word
    chk("e31_addr", zbt_addr, 19'h40);
    wr_valid = 1'b0; rd_req = 1'b0;
    tick(); // E32 pop
    chk("e32_we_n", zbt_we_n, 0);
    chk("e32_addr", zbt_addr, 19'h3000);
    tick(); // E33
    rst_n = 1'b0;
    we_h0 = 1'b0; we_h1 = 1'b0; we_h2 = 1'b0;
    #1;
    chk("rst2_state", state, 0);
    chk("rst2_we_n", zbt_we_n, 1);
    chk("rst2_rvalid", rd_valid, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_wready", wr_ready, 1);
    chk("rst2_addr", zbt_addr, 0);
    tick(); // E34 held in reset
    chk("rst2_wdata", zbt_wdata, 0);
    chk("rst2_rvalid2", rd_valid, 0);
    rst_n = 1'b1;
    start = 1'b1; stop = 1'b1;
    tick(); // E35 start wins in IDLE
    chk("e35_state", state, 1);
    start = 1'b0;
    tick(); // E36 stop in RUN
    chk("e36_state", state, 2);
    chk("e36_we_n", zbt_we_n, 1);
    stop = 1'b0;
    tick(); // E37 empty FIFO: straight back to IDLE
    chk("e37_state", state, 0);
    chk("e37_we_n", zbt_we_n, 1);
    chk("e37_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
